wb_slv_port: RTL and testbench

WB_SLV_PORT -- requirements
Module: wb_slv_port

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_slv_mem.sv | 52 +++++
 rtl/wb_slv_port.sv | 87 ++++++++
 tb/tb_wb_slv_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone slave constants and helpers.
//   ADR_W      - byte address width of the bus
//   sel_w()    - number of byte-lane selects for a given data width
//   byte_merge - replace the selected byte lanes of a word with new data
package wb_pkg;

  localparam int unsigned ADR_W     = 32;
  localparam int unsigned MAX_BUS_W = 64;
  localparam int unsigned MAX_SEL_W = MAX_BUS_W / 8;

  // One select bit per byte lane.
  function automatic int unsigned sel_w(input int unsigned bus_w);
    return bus_w / 8;
  endfunction

  // Lanes with sel=1 take new_word, all others keep old_word. Sized for the
  // widest supported bus; callers zero-extend and truncate around it.
  function automatic logic [MAX_BUS_W-1:0] byte_merge(
    input logic [MAX_BUS_W-1:0] old_word,
    input logic [MAX_BUS_W-1:0] new_word,
    input logic [MAX_SEL_W-1:0] sel
  );
    logic [MAX_BUS_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MAX_SEL_W); i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_slv_mem.sv
// wb_slv_mem: byte-enable storage array with registered, lane-masked read.
//   clk, rst_n - clock, async active-low reset (clears every word)
//   wr_en      - merge wdata into word idx on the selected lanes
//   rd_en      - capture word idx (unselected lanes zeroed) into rdata
//   idx, sel   - word index and byte-lane selects
//   wdata      - write data
//   rdata      - registered read data, zero in any cycle without rd_en
module wb_slv_mem
  import wb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]      idx,
  input  logic [sel_w(BUS_WIDTH)-1:0]   sel,
  input  logic [BUS_WIDTH-1:0]          wdata,
  output logic [BUS_WIDTH-1:0]          rdata
);

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] wr_word_d;
  logic [BUS_WIDTH-1:0] rdata_d;
  logic [BUS_WIDTH-1:0] rdata_q;

  // Merged write word and masked read word for the addressed entry.
  always_comb begin
    wr_word_d = BUS_WIDTH'(byte_merge(MAX_BUS_W'(mem_q[idx]), MAX_BUS_W'(wdata),
                                      MAX_SEL_W'(sel)));
    rdata_d   = '0;
    if (rd_en) begin
      rdata_d = BUS_WIDTH'(byte_merge('0, MAX_BUS_W'(mem_q[idx]), MAX_SEL_W'(sel)));
    end
  end

  // Storage and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en) mem_q[idx] <= wr_word_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_slv_port.sv
// wb_slv_port: Wishbone classic slave with a local byte-addressed memory.
//   clk, rst_n      - clock, async active-low reset
//   cyc, stb        - bus cycle / transfer strobe from master
//   adr, sel, we    - byte address, byte-lane selects, write enable
//   datSlvIn        - write data from master
//   datMstIn        - read data to master (zero unless ack)
//   ack, err        - registered one-cycle normal / error termination
module wb_slv_port
  import wb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cyc,
  input  logic                          stb,
  input  logic [ADR_W-1:0]              adr,
  input  logic [sel_w(BUS_WIDTH)-1:0]   sel,
  input  logic                          we,
  input  logic [BUS_WIDTH-1:0]          datSlvIn,
  output logic [BUS_WIDTH-1:0]          datMstIn,
  output logic                          ack,
  output logic                          err
);

  localparam int unsigned SEL_W  = sel_w(BUS_WIDTH);
  localparam int unsigned OFF_W  = $clog2(SEL_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned SPAN_W = ADR_W + 1;
  localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(DEPTH * SEL_W);

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              req_valid;
  logic              bad_req;
  logic [ADR_W-1:0]  offset;
  logic [IDX_W-1:0]  word_idx;
  logic              mem_wr;
  logic              mem_rd;

  // Request decode: a new request is only taken when no termination is
  // showing, which yields one transfer per two cycles with stb held.
  always_comb begin
    offset    = adr - BASE_ADR;
    bad_req   = (adr < BASE_ADR)
              || ({1'b0, offset} >= SPAN)
              || ((offset & ADR_W'(SEL_W - 1)) != '0)
              || (sel == '0);
    req_valid = cyc && stb && !ack_q && !err_q;
    ack_d     = req_valid && !bad_req;
    err_d     = req_valid && bad_req;
    word_idx  = offset[OFF_W +: IDX_W];
    mem_wr    = ack_d && we;
    mem_rd    = ack_d && !we;
  end

  // Termination registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  wb_slv_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (mem_wr),
    .rd_en (mem_rd),
    .idx   (word_idx),
    .sel   (sel),
    .wdata (datSlvIn),
    .rdata (datMstIn)
  );

  assign ack = ack_q;
  assign err = err_q;

endmodule

// File: tb/tb_wb_slv_port.sv
// tb_wb_slv_port: directed and randomized checks of wb_slv_port against a
// word-array reference model (default parameters: 32-bit, 256 words, base 0).
module tb_wb_slv_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] datSlvIn = '0;
  logic [31:0] datMstIn;
  logic        ack;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [256];

  wb_slv_port #(
    .BUS_WIDTH (32),
    .DEPTH     (256),
    .BASE_ADR  (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cyc      (cyc),
    .stb      (stb),
    .adr      (adr),
    .sel      (sel),
    .we       (we),
    .datSlvIn (datSlvIn),
    .datMstIn (datMstIn),
    .ack      (ack),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [3:0] s);
    return (a >= 32'h400) || (a % 4 != 0) || (s == 4'h0);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  // Single isolated transfer; entered and left 1 time unit after a rising edge.
  task automatic xfer(input string tag, input logic [31:0] a, input logic [3:0] s,
                      input logic w, input logic [31:0] d);
    bit          e;
    logic [31:0] exp_dat;
    e       = is_bad(a, s);
    exp_dat = (w || e) ? 32'h0 : lanes(ref_mem[a[9:2]], s);
    cyc = 1'b1; stb = 1'b1; adr = a; sel = s; we = w; datSlvIn = d;
    @(posedge clk); #1;
    check_eq({tag, " ack"}, 32'(ack), 32'(!e));
    check_eq({tag, " err"}, 32'(err), 32'(e));
    check_eq({tag, " dat"}, datMstIn, exp_dat);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, " ack end"}, 32'(ack), 32'h0);
    check_eq({tag, " err end"}, 32'(err), 32'h0);
    check_eq({tag, " dat end"}, datMstIn, 32'h0);
    if (w && !e) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
  endtask

  initial begin
    int          n_ack;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          r;

    // Reset state.
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst ack", 32'(ack), 32'h0);
    check_eq("rst err", 32'(err), 32'h0);
    check_eq("rst dat", datMstIn, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read.
    xfer("wr 10", 32'h10, 4'hF, 1'b1, 32'hDEADBEEF);
    xfer("rd 10", 32'h10, 4'hF, 1'b0, 32'h0);
    check_eq("model 10", ref_mem[4], 32'hDEADBEEF);

    // Partial-lane write over zeroed storage.
    xfer("wr 20 part", 32'h20, 4'b0101, 1'b1, 32'h11223344);
    xfer("rd 20", 32'h20, 4'hF, 1'b0, 32'h0);
    check_eq("model 20", ref_mem[8], 32'h00220044);
    xfer("rd 20 sel", 32'h20, 4'b0110, 1'b0, 32'h0);

    // Error terminations, storage untouched.
    xfer("rd oor", 32'h400, 4'hF, 1'b0, 32'h0);
    xfer("rd misal", 32'h3, 4'hF, 1'b0, 32'h0);
    xfer("wr sel0", 32'h10, 4'h0, 1'b1, 32'h0);
    xfer("wr oor", 32'h404, 4'hF, 1'b1, 32'h12345678);
    xfer("rd 10 again", 32'h10, 4'hF, 1'b0, 32'h0);

    // Four reads with stb held: ack on alternate cycles.
    for (int i = 0; i < 4; i++) xfer("pre wr", 32'(i * 4), 4'hF, 1'b1, $urandom);
    n_ack = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check_eq("pipe ack", 32'(ack), 32'(k % 2 == 0));
      check_eq("pipe err", 32'(err), 32'h0);
      if (ack) begin
        check_eq("pipe dat", datMstIn, ref_mem[n_ack % 256]);
        n_ack++;
        if (n_ack >= 4) begin
          cyc = 1'b0; stb = 1'b0;
        end else begin
          adr = 32'(n_ack * 4);
        end
      end else begin
        check_eq("pipe dat idle", datMstIn, 32'h0);
      end
    end
    check_eq("pipe count", 32'(n_ack), 32'd4);

    // Write then read of the same word on consecutive transfers.
    d = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h30; datSlvIn = d;
    @(posedge clk); #1;
    check_eq("raw wr ack", 32'(ack), 32'h1);
    we = 1'b0;
    @(posedge clk); #1;
    check_eq("raw gap ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
    check_eq("raw rd ack", 32'(ack), 32'h1);
    check_eq("raw rd dat", datMstIn, d);
    cyc = 1'b0; stb = 1'b0;
    ref_mem[12] = d;
    @(posedge clk); #1;

    // cyc held without stb.
    cyc = 1'b1; stb = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_eq("idle term", 32'({ack, err}), 32'h0);
    end
    cyc = 1'b0;

    // Request withdrawn before the sampling edge.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h10; datSlvIn = 32'h0BADF00D;
    #3;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_eq("withdraw term", 32'({ack, err}), 32'h0);
    xfer("rd after withdraw", 32'h10, 4'hF, 1'b0, 32'h0);

    // Reset while a termination is showing cancels it at once.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; datSlvIn = 32'h00001234;
    @(posedge clk); #1;
    check_eq("pre rst ack", 32'(ack), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst cancels ack", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #2 rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1;

    // Reset during a pending write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; datSlvIn = 32'hA5A5A5A5;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst pend term", 32'({ack, err}), 32'h0);
    check_eq("rst pend dat", datMstIn, 32'h0);
    @(posedge clk); #1;
    check_eq("rst held ack", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #2 rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
    check_eq("post rst term", 32'({ack, err}), 32'h0);
    xfer("rd 8 after rst", 32'h8, 4'hF, 1'b0, 32'h0);
    xfer("rd 10 after rst", 32'h10, 4'hF, 1'b0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 6) a = 32'($urandom_range(0, 255) * 4);
      else if (r == 7) a = $urandom | 32'h400;
      else if (r == 8) a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else             a = 32'h3FC;
      s = 4'($urandom_range(0, 15));
      xfer("rand", a, s, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
